// File: rtl/data_rx_deframer.sv
`default_nettype none
// ============================================================================
// Module   : data_rx_deframer
// Purpose  : Wake-up receiver frame deframer. After the synchronizer opens the
//            frame window (data_clk_enb rising), samples the comparator output
//            at mid-bit, checks the all-zero preamble, packs the payload
//            MSB-first into bytes and presents them through a small
//            first-word-fall-through FIFO with a valid/ready handshake.
// Ports    : clki, rst          - clock, async active-high reset
//            data_clk_enb       - frame window, synchronous to clki
//            comp_out           - raw comparator output (asynchronous)
//            byte_data/valid    - FIFO head byte and not-empty flag
//            byte_ready         - consumer accepts head when valid is high
//            frame_done         - 1-cycle pulse, full frame received
//            frame_abort        - 1-cycle pulse, preamble error / early stop
//            preamble_err       - sticky, last frame failed the preamble
//            overflow           - sticky, a byte was dropped on a full FIFO
// Revision : 1.0 - initial release
// ============================================================================
module data_rx_deframer #(
  parameter int DATARATE_DIV  = 100,
  parameter int PREAMBLE_BITS = 192,
  parameter int FRAME_BITS    = 1000,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic       clki,
  input  logic       rst,
  input  logic       data_clk_enb,
  input  logic       comp_out,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       frame_done,
  output logic       frame_abort,
  output logic       preamble_err,
  output logic       overflow
);

  localparam int CYC_W  = $clog2(DATARATE_DIV);
  localparam int BIT_W  = $clog2(FRAME_BITS);
  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

  localparam logic [CYC_W-1:0] C_CYC_ONE    = CYC_W'(1);
  localparam logic [CYC_W-1:0] C_CYC_LAST   = CYC_W'(DATARATE_DIV - 1);
  localparam logic [CYC_W-1:0] C_CYC_SAMPLE = CYC_W'(DATARATE_DIV / 2);
  localparam logic [BIT_W-1:0] C_BIT_ONE    = BIT_W'(1);
  localparam logic [BIT_W-1:0] C_PRE_LAST   = BIT_W'(PREAMBLE_BITS - 1);
  localparam logic [BIT_W-1:0] C_FRAME_LAST = BIT_W'(FRAME_BITS - 1);
  localparam logic [PTR_W-1:0] C_DEPTH      = PTR_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] C_PTR_ONE    = PTR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_PAYLOAD  = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               sync1_q, sync1_d, sync2_q, sync2_d;
  logic               enb_q, enb_d;
  logic [CYC_W-1:0]   cyc_cnt_q, cyc_cnt_d;
  logic [BIT_W-1:0]   bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic               push_q, push_d;
  logic               last_q, last_d;
  logic               frame_done_q, frame_done_d;
  logic               frame_abort_q, frame_abort_d;
  logic               preamble_err_q, preamble_err_d;
  logic               overflow_q, overflow_d;
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [7:0]         mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]         byte_data_q, byte_data_d;
  logic               byte_valid_q, byte_valid_d;

  logic               w_start, w_sample, w_clr_ovf;
  logic               w_pop, w_full, w_write;

  // --------------------------------------------------------------------------
  // Frame state machine: next-state and datapath control
  // --------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    sync1_d        = comp_out;
    sync2_d        = sync1_q;
    enb_d          = data_clk_enb;
    cyc_cnt_d      = cyc_cnt_q;
    bit_idx_d      = bit_idx_q;
    shift_d        = shift_q;
    bit_cnt_d      = bit_cnt_q;
    push_d         = 1'b0;
    last_d         = 1'b0;
    frame_abort_d  = 1'b0;
    preamble_err_d = preamble_err_q;
    w_clr_ovf      = 1'b0;
    w_start        = data_clk_enb & ~enb_q;
    w_sample       = (cyc_cnt_q == C_CYC_SAMPLE);
    // A frame's last byte is pushed the cycle after its last sample, so the
    // done pulse lands two cycles after that sample.
    frame_done_d   = push_q & last_q;

    case (state_q)
      ST_IDLE: begin
        if (w_start) begin
          // The start cycle itself is count 0 of bit 0, so the counter resumes
          // at 1; this puts sample n at start + n*DIV + DIV/2.
          cyc_cnt_d      = C_CYC_ONE;
          bit_idx_d      = '0;
          bit_cnt_d      = 3'd0;
          preamble_err_d = 1'b0;
          w_clr_ovf      = 1'b1;
          state_d        = ST_PREAMBLE;
        end
      end

      ST_PREAMBLE, ST_PAYLOAD: begin
        if (!data_clk_enb) begin
          // Window closed early: any partial byte is simply abandoned.
          frame_abort_d = 1'b1;
          bit_cnt_d     = 3'd0;
          state_d       = ST_IDLE;
        end else begin
          if (cyc_cnt_q == C_CYC_LAST) begin
            cyc_cnt_d = '0;
            bit_idx_d = bit_idx_q + C_BIT_ONE;
          end else begin
            cyc_cnt_d = cyc_cnt_q + C_CYC_ONE;
          end

          if (w_sample) begin
            if (state_q == ST_PREAMBLE) begin
              if (sync2_q) begin
                preamble_err_d = 1'b1;
                frame_abort_d  = 1'b1;
                state_d        = ST_IDLE;
              end else if (bit_idx_q == C_PRE_LAST) begin
                bit_cnt_d = 3'd0;
                state_d   = ST_PAYLOAD;
              end
            end else begin
              shift_d   = {shift_q[6:0], sync2_q};
              bit_cnt_d = bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                push_d = 1'b1;
                // Payload length is a whole number of bytes, so the final
                // frame bit always completes a byte.
                if (bit_idx_q == C_FRAME_LAST) begin
                  last_d  = 1'b1;
                  state_d = ST_DONE;
                end
              end
            end
          end
        end
      end

      ST_DONE: begin
        if (!data_clk_enb) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output FIFO. Head data/valid are registered from the next-state pointers
  // so the consumer's ready never reaches an output combinationally.
  // --------------------------------------------------------------------------
  always_comb begin
    w_pop   = byte_valid_q & byte_ready;
    w_full  = ((wr_ptr_q - rd_ptr_q) == C_DEPTH);
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    w_write = push_q & (~w_full | w_pop);

    mem_d = mem_q;
    if (w_write) begin
      mem_d[wr_ptr_q[ADDR_W-1:0]] = shift_q;
    end

    wr_ptr_d = wr_ptr_q;
    if (w_write) begin
      wr_ptr_d = wr_ptr_q + C_PTR_ONE;
    end
    rd_ptr_d = rd_ptr_q;
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + C_PTR_ONE;
    end

    byte_valid_d = (wr_ptr_d != rd_ptr_d);
    byte_data_d  = mem_d[rd_ptr_d[ADDR_W-1:0]];

    if (w_clr_ovf) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q | (push_q & w_full & ~w_pop);
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      enb_q          <= 1'b0;
      cyc_cnt_q      <= '0;
      bit_idx_q      <= '0;
      shift_q        <= 8'h00;
      bit_cnt_q      <= 3'd0;
      push_q         <= 1'b0;
      last_q         <= 1'b0;
      frame_done_q   <= 1'b0;
      frame_abort_q  <= 1'b0;
      preamble_err_q <= 1'b0;
      overflow_q     <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      byte_data_q    <= 8'h00;
      byte_valid_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      enb_q          <= enb_d;
      cyc_cnt_q      <= cyc_cnt_d;
      bit_idx_q      <= bit_idx_d;
      shift_q        <= shift_d;
      bit_cnt_q      <= bit_cnt_d;
      push_q         <= push_d;
      last_q         <= last_d;
      frame_done_q   <= frame_done_d;
      frame_abort_q  <= frame_abort_d;
      preamble_err_q <= preamble_err_d;
      overflow_q     <= overflow_d;
      mem_q          <= mem_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      byte_data_q    <= byte_data_d;
      byte_valid_q   <= byte_valid_d;
    end
  end

  assign byte_data    = byte_data_q;
  assign byte_valid   = byte_valid_q;
  assign frame_done   = frame_done_q;
  assign frame_abort  = frame_abort_q;
  assign preamble_err = preamble_err_q;
  assign overflow     = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_data_rx_deframer.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_rx_deframer
// Purpose  : Self-checking bench for data_rx_deframer (DATARATE_DIV = 10).
//            Stimulus queues the bytes each scenario should deliver; a monitor
//            pops and compares on every accepted handshake and records the
//            frame_done / frame_abort pulses with their cycle numbers.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_rx_deframer;

  localparam int DIV    = 10;
  localparam int PRE    = 192;
  localparam int FRAME  = 1000;
  localparam int NBYTES = (FRAME - PRE) / 8;

  logic       clki = 1'b0;
  logic       rst;
  logic       data_clk_enb;
  logic       comp_out;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;
  logic       frame_done;
  logic       frame_abort;
  logic       preamble_err;
  logic       overflow;

  always #5 clki = ~clki;

  data_rx_deframer #(
    .DATARATE_DIV (DIV),
    .PREAMBLE_BITS(PRE),
    .FRAME_BITS   (FRAME),
    .FIFO_DEPTH   (4)
  ) u_dut (
    .clki        (clki),
    .rst         (rst),
    .data_clk_enb(data_clk_enb),
    .comp_out    (comp_out),
    .byte_data   (byte_data),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .frame_done  (frame_done),
    .frame_abort (frame_abort),
    .preamble_err(preamble_err),
    .overflow    (overflow)
  );

  int cyc = 0;
  always @(posedge clki) cyc <= cyc + 1;

  int         n_pass  = 0;
  int         n_total = 0;
  logic [7:0] exp_q[$];
  logic [7:0] pay [NBYTES];
  logic [7:0] mon_exp;
  int         done_cnt, abort_cnt, done_cyc, abort_cyc, frame_s;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Scoreboard monitor, sampling on the inactive edge.
  always @(negedge clki) begin
    if (byte_valid && byte_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_byte", int'(byte_data), -1);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("byte_data", int'(byte_data), int'(mon_exp));
      end
    end
    if (frame_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (frame_abort) begin
      abort_cnt++;
      abort_cyc = cyc;
    end
  end

  task automatic clr_events();
    done_cnt  = 0;
    abort_cnt = 0;
    done_cyc  = -1;
    abort_cyc = -1;
  endtask

  task automatic wait_cyc(input int k);
    repeat (k) @(posedge clki);
    #1;
  endtask

  task automatic new_payload();
    for (int i = 0; i < NBYTES; i++) pay[i] = 8'($urandom);
  endtask

  task automatic expect_bytes(input int count);
    for (int i = 0; i < count; i++) exp_q.push_back(pay[i]);
  endtask

  // Reference bit stream: preamble zeros (optionally one error bit), then the
  // payload bytes MSB first.
  function automatic logic frame_bit(input int n, input int err_bit);
    int p;
    if (n < PRE) return (n == err_bit);
    p = n - PRE;
    return pay[p / 8][7 - (p % 8)];
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_byte_data"},    int'(byte_data),    0);
    chk({tag, "_byte_valid"},   int'(byte_valid),   0);
    chk({tag, "_frame_done"},   int'(frame_done),   0);
    chk({tag, "_frame_abort"},  int'(frame_abort),  0);
    chk({tag, "_preamble_err"}, int'(preamble_err), 0);
    chk({tag, "_overflow"},     int'(overflow),     0);
  endtask

  // Drives one frame. Each bit is applied at the start of its bit window,
  // DIV/2 cycles ahead of its sample point. stop_bit drops the window at the
  // start of that bit; rst_bit pulses reset off-edge at that point instead.
  task automatic drive_frame(input int stop_bit, input int err_bit, input int rst_bit);
    @(posedge clki);
    #1;
    data_clk_enb = 1'b1;
    frame_s      = cyc;
    for (int n = 0; n < FRAME; n++) begin
      if (n == stop_bit) begin
        data_clk_enb = 1'b0;
        return;
      end
      if (n == rst_bit) begin
        #1;
        rst          = 1'b1;
        data_clk_enb = 1'b0;
        #1;
        chk_all_zero("async_rst");
        rst = 1'b0;
        return;
      end
      comp_out = frame_bit(n, err_bit);
      repeat (DIV) @(posedge clki);
      #1;
    end
    data_clk_enb = 1'b0;
  endtask

  task automatic clean_frame(input string tag);
    int s;
    new_payload();
    expect_bytes(NBYTES);
    clr_events();
    drive_frame(-1, -1, -1);
    s = frame_s;
    wait_cyc(10);
    chk({tag, "_done_cnt"},     done_cnt, 1);
    chk({tag, "_done_cycle"},   done_cyc - s, FRAME * DIV - 3);
    chk({tag, "_abort_cnt"},    abort_cnt, 0);
    chk({tag, "_preamble_err"}, int'(preamble_err), 0);
    chk({tag, "_overflow"},     int'(overflow), 0);
    chk({tag, "_missing"},      exp_q.size(), 0);
  endtask

  initial begin
    int s;
    int guard;
    rst          = 1'b1;
    data_clk_enb = 1'b0;
    comp_out     = 1'b0;
    byte_ready   = 1'b1;
    frame_s      = -1;
    clr_events();
    wait_cyc(3);
    chk_all_zero("reset");
    rst = 1'b0;
    wait_cyc(3);

    // Clean frame, first bytes A5, 3C.
    new_payload();
    pay[0] = 8'hA5;
    pay[1] = 8'h3C;
    expect_bytes(NBYTES);
    clr_events();
    drive_frame(-1, -1, -1);
    s = frame_s;
    wait_cyc(10);
    chk("clean_done_cnt",     done_cnt, 1);
    chk("clean_done_cycle",   done_cyc - s, 9997);
    chk("clean_abort_cnt",    abort_cnt, 0);
    chk("clean_preamble_err", int'(preamble_err), 0);
    chk("clean_overflow",     int'(overflow), 0);
    chk("clean_missing",      exp_q.size(), 0);

    // Preamble error at bit 100, then a clean frame clears the flag.
    new_payload();
    clr_events();
    drive_frame(110, 100, -1);
    s = frame_s;
    wait_cyc(10);
    chk("pre_abort_cnt",    abort_cnt, 1);
    chk("pre_abort_cycle",  abort_cyc - s, 1006);
    chk("pre_preamble_err", int'(preamble_err), 1);
    chk("pre_done_cnt",     done_cnt, 0);
    chk("pre_byte_valid",   int'(byte_valid), 0);
    clean_frame("after_pre");

    // Window drops after 3 bytes plus 5 payload bits.
    new_payload();
    expect_bytes(3);
    clr_events();
    drive_frame(PRE + 29, -1, -1);
    s = frame_s;
    wait_cyc(10);
    chk("drop_abort_cnt",   abort_cnt, 1);
    chk("drop_abort_cycle", abort_cyc - s, (PRE + 29) * DIV + 1);
    chk("drop_done_cnt",    done_cnt, 0);
    chk("drop_missing",     exp_q.size(), 0);
    chk("drop_byte_valid",  int'(byte_valid), 0);

    // Backpressure for the whole frame: only the first 4 bytes survive.
    new_payload();
    expect_bytes(4);
    clr_events();
    byte_ready = 1'b0;
    drive_frame(-1, -1, -1);
    wait_cyc(10);
    chk("bp_done_cnt",   done_cnt, 1);
    chk("bp_overflow",   int'(overflow), 1);
    chk("bp_byte_valid", int'(byte_valid), 1);
    byte_ready = 1'b1;
    wait_cyc(10);
    chk("bp_drained",      exp_q.size(), 0);
    chk("bp_empty_after",  int'(byte_valid), 0);
    chk("bp_overflow_sticky", int'(overflow), 1);

    // Full FIFO: ready pulsed exactly in the 5th byte's push cycle.
    new_payload();
    expect_bytes(5);
    clr_events();
    byte_ready = 1'b0;
    frame_s    = -1;
    fork
      drive_frame(PRE + 44, -1, -1);
      begin
        guard = 0;
        do begin
          @(posedge clki);
          #1;
          guard++;
        end while ((frame_s < 0 || cyc != frame_s + (PRE + 39) * DIV + DIV / 2 + 1) && guard < 5000);
        chk("pp_pulse_reached", int'(guard < 5000), 1);
        byte_ready = 1'b1;
        wait_cyc(1);
        byte_ready = 1'b0;
      end
    join
    s = frame_s;
    wait_cyc(10);
    chk("pp_overflow",    int'(overflow), 0);
    chk("pp_abort_cnt",   abort_cnt, 1);
    chk("pp_abort_cycle", abort_cyc - s, (PRE + 44) * DIV + 1);
    chk("pp_byte_valid",  int'(byte_valid), 1);
    byte_ready = 1'b1;
    wait_cyc(10);
    chk("pp_drained",     exp_q.size(), 0);
    chk("pp_empty_after", int'(byte_valid), 0);

    // Asynchronous reset mid-payload, then a normal frame.
    new_payload();
    expect_bytes(7);
    clr_events();
    drive_frame(-1, -1, PRE + 58);
    wait_cyc(20);
    chk("rst_abort_cnt",  abort_cnt, 0);
    chk("rst_done_cnt",   done_cnt, 0);
    chk("rst_byte_valid", int'(byte_valid), 0);
    chk("rst_missing",    exp_q.size(), 0);
    clean_frame("after_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
